// File: rtl/cb_arb_pkg.sv
// -----------------------------------------------------------------------------
// cb_arb_pkg
// Purpose : shared definitions for the cb_en_arbiter block: FSM state
//           encoding, default parameter values, gap-counter width and a small
//           index-wrap helper used by the round-robin pointer update.
// Ports   : none (package).
// Config  : CB_ARB_LOCK_EN (used by the interface and top, not here).
// -----------------------------------------------------------------------------
package cb_arb_pkg;

  // Default geometry of the arbiter.
  localparam int DEF_N     = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_GAP   = 1;

  // Width of the quiet-gap counter; holds GAP-1 for GAP up to 15.
  localparam int GAP_CNT_W = 4;

  // FSM encoding: IDLE=0, GRANT=1, GAP=2.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Next index with wrap n-1 -> 0.
  function automatic int wrap_inc(input int idx, input int n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/cb_en_arbiter_if.sv
// -----------------------------------------------------------------------------
// cb_en_arbiter_if
// Purpose : bundles the requester-side handshake and the shared-register
//           write port of cb_en_arbiter.
// Signals : req[N]      request per requester, held until ack
//           din[N*W]    flattened data, slice i = din[i*W +: W]
//           lock[N]     keep ownership across writes (CB_ARB_LOCK_EN only)
//           gnt[N]      registered one-hot grant
//           ack[N]      same as gnt
//           reg_en      one-cycle enable to the shared register
//           reg_d[W]    data to the shared register
//           busy        arbiter in GRANT or GAP
// Modports: master = requester side, slave = arbiter side.
// Config  : CB_ARB_LOCK_EN adds the lock signal.
// -----------------------------------------------------------------------------
interface cb_en_arbiter_if #(
  parameter int N = cb_arb_pkg::DEF_N,
  parameter int W = cb_arb_pkg::DEF_W
);

  logic [N-1:0]   req;
  logic [N*W-1:0] din;
`ifdef CB_ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           reg_en;
  logic [W-1:0]   reg_d;
  logic           busy;

`ifdef CB_ARB_LOCK_EN
  modport master (output req, din, lock, input gnt, ack, reg_en, reg_d, busy);
  modport slave  (input req, din, lock, output gnt, ack, reg_en, reg_d, busy);
`else
  modport master (output req, din, input gnt, ack, reg_en, reg_d, busy);
  modport slave  (input req, din, output gnt, ack, reg_en, reg_d, busy);
`endif

endinterface

// File: rtl/cb_rr_pick.sv
// -----------------------------------------------------------------------------
// cb_rr_pick
// Purpose : combinational rotate-priority picker. Scans requests starting at
//           the pointer, upward with wrap, and reports the first one set.
// Ports   : i_req[N]     request vector
//           i_ptr[PW]    index with highest priority (must be < N)
//           o_onehot[N]  one-hot winner (zero when no request)
//           o_idx[PW]    winner index (zero when no request)
//           o_valid      at least one request present
// -----------------------------------------------------------------------------
module cb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  // w_cand[k] is the requester index holding priority rank k.
  logic [PW-1:0] w_cand [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign w_cand[gi] = PW'(((int'(i_ptr) + gi) >= N) ? (int'(i_ptr) + gi - N)
                                                        : (int'(i_ptr) + gi));
  end

  assign o_valid = |i_req;

  // Walk ranks from lowest to highest priority so the last hit (rank 0 side)
  // is the one that sticks.
  always_comb begin
    o_idx    = '0;
    o_onehot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_idx = w_cand[k];
      end
    end
    if (o_valid) begin
      o_onehot[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cb_en_arbiter.sv
// -----------------------------------------------------------------------------
// cb_en_arbiter
// Purpose : round-robin arbiter sharing one clock-enabled capture register
//           among N requesters. Each write is a one-cycle reg_en pulse with
//           the winner's data, followed by GAP forced idle cycles.
// Ports   : clk   system clock, rising edge
//           rst   asynchronous active-high reset
//           bus   cb_en_arbiter_if.slave (req, din, [lock], gnt, ack,
//                 reg_en, reg_d, busy)
// Params  : N (2..8) requesters, W data width, GAP (1..15) idle cycles.
// Config  : CB_ARB_LOCK_EN enables the lock/ownership feature.
// -----------------------------------------------------------------------------
module cb_en_arbiter
  import cb_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int W   = DEF_W,
  parameter int GAP = DEF_GAP
) (
  input logic             clk,
  input logic             rst,
  cb_en_arbiter_if.slave  bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t               r_state;
  state_t               w_state_next;
  logic [GAP_CNT_W-1:0] r_gap_cnt;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        w_ptr_next;
  logic [N-1:0]         r_gnt;
  logic                 r_reg_en;
  logic [W-1:0]         r_reg_d;

  logic [N-1:0]         w_pick_oh;
  logic [PW-1:0]        w_pick_idx;
  logic                 w_any_req;
  logic [N-1:0]         w_sel_oh;
  logic [PW-1:0]        w_sel_idx;
  logic                 w_arb;
  logic [W-1:0]         w_slice [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign w_slice[gi] = bus.din[gi*W +: W];
  end

  cb_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_valid  (w_any_req)
  );

  // Next-state logic. Arbitration happens on exactly the edges that enter
  // GRANT, so w_arb is derived from the next state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any_req) w_state_next = ST_GRANT;
      ST_GRANT: w_state_next = ST_GAP;
      ST_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_next = w_any_req ? ST_GRANT : ST_IDLE;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign w_arb = (w_state_next == ST_GRANT);

`ifdef CB_ARB_LOCK_EN
  // Owner bookkeeping: r_owner remembers the last winner; r_owner_vld is
  // taken from that winner's lock bit at the edge that ends GRANT.
  logic [PW-1:0] r_owner;
  logic          r_owner_vld;
  logic          w_owner_hit;

  assign w_owner_hit = r_owner_vld && bus.req[r_owner] && bus.lock[r_owner];

  // A retained owner wins without moving the pointer; otherwise plain
  // round-robin applies in the same arbitration.
  always_comb begin
    w_sel_oh   = w_pick_oh;
    w_sel_idx  = w_pick_idx;
    w_ptr_next = PW'(wrap_inc(int'(w_pick_idx), N));
    if (w_owner_hit) begin
      w_sel_oh          = '0;
      w_sel_oh[r_owner] = 1'b1;
      w_sel_idx         = r_owner;
      w_ptr_next        = r_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
    end else if (w_arb) begin
      r_owner     <= w_sel_idx;
      r_owner_vld <= 1'b0;
    end else if (r_state == ST_GRANT) begin
      r_owner_vld <= bus.lock[r_owner];
    end
  end
`else
  assign w_sel_oh   = w_pick_oh;
  assign w_sel_idx  = w_pick_idx;
  assign w_ptr_next = PW'(wrap_inc(int'(w_pick_idx), N));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_reg_en  <= 1'b0;
      r_reg_d   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_reg_en <= w_arb;
      r_gnt    <= w_arb ? w_sel_oh : '0;
      // Data is captured at the arbitration edge and held until the next one.
      if (w_arb) begin
        r_reg_d <= w_slice[w_sel_idx];
        r_ptr   <= w_ptr_next;
      end
      // Counter is loaded while leaving GRANT so GAP spans exactly GAP cycles.
      if (r_state == ST_GRANT) begin
        r_gap_cnt <= GAP_CNT_W'(GAP - 1);
      end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GAP_CNT_W'(1);
      end
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.ack    = r_gnt;
  assign bus.reg_en = r_reg_en;
  assign bus.reg_d  = r_reg_d;
  assign bus.busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cb_en_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cb_en_arbiter
// Purpose : self-checking bench for cb_en_arbiter. Two instances (GAP=1 and
//           GAP=3) are driven side by side; every cycle both are compared with
//           a slot-based reference model. Build with +define+CB_ARB_LOCK_EN to
//           also exercise the lock feature.
// -----------------------------------------------------------------------------
module tb_cb_en_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cb_en_arbiter_if #(.N(N), .W(W)) if0 ();
  cb_en_arbiter_if #(.N(N), .W(W)) if1 ();

  cb_en_arbiter #(.N(N), .W(W), .GAP(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  cb_en_arbiter #(.N(N), .W(W), .GAP(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic [N-1:0]   req_v  [2];
  logic [N*W-1:0] din_v  [2];
  logic [N-1:0]   lock_v [2];

  assign if0.req = req_v[0];
  assign if0.din = din_v[0];
  assign if1.req = req_v[1];
  assign if1.din = din_v[1];
`ifdef CB_ARB_LOCK_EN
  assign if0.lock = lock_v[0];
  assign if1.lock = lock_v[1];
`endif

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  // Reference model: a write may start at any edge at or after 'earliest';
  // each write blocks the next 1+GAP edges.
  typedef struct {
    int         ptr;
    int         earliest;
    int         owner;
    int         last_w;
    int         last_e;
    int         ecnt;
    logic [3:0] gnt;
    logic       en;
    logic [7:0] d;
    logic       busy;
  } mdl_t;
  mdl_t m [2];
  int   gap_of [2];

  typedef struct { int w; int e; } wr_t;
  wr_t log0[$];
  wr_t log1[$];

  logic       prev_en [2];
  logic [3:0] last_ack [2];

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [7:0]  d;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    int r = -1;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].ptr = 0;      m[k].earliest = 0; m[k].owner = -1;
      m[k].last_w = -1;  m[k].last_e = -10; m[k].ecnt = 0;
      m[k].gnt = '0;     m[k].en = 1'b0;    m[k].d = '0; m[k].busy = 1'b0;
      prev_en[k] = 1'b0; last_ack[k] = '0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge(input int k);
    int e, w;
    logic [3:0]  rq;
    logic [31:0] dv;
    logic [3:0]  lk;
    rq = req_v[k]; dv = din_v[k]; lk = lock_v[k];
    e  = m[k].ecnt;
    if (m[k].last_e == e - 1 && m[k].last_w >= 0)
      m[k].owner = lk[m[k].last_w] ? m[k].last_w : -1;
    m[k].gnt = '0;
    m[k].en  = 1'b0;
    if (e >= m[k].earliest && rq != 0) begin
      w = -1;
      if (m[k].owner >= 0 && rq[m[k].owner] && lk[m[k].owner]) begin
        w = m[k].owner;
      end else begin
        m[k].owner = -1;
        for (int j = 0; j < N; j++)
          if (w < 0 && rq[(m[k].ptr + j) % N]) w = (m[k].ptr + j) % N;
        m[k].ptr = (w + 1) % N;
      end
      m[k].gnt[w]   = 1'b1;
      m[k].en       = 1'b1;
      m[k].d        = dv[w*W +: W];
      m[k].earliest = e + 1 + gap_of[k];
      m[k].last_e   = e;
      m[k].last_w   = w;
    end
    m[k].busy = (e < m[k].earliest);
    m[k].ecnt++;
  endtask

  // One clock: predict, let the edge happen, compare on the falling edge.
  task automatic step();
    logic [3:0] g [2];
    logic [3:0] a [2];
    logic       en [2];
    logic       b [2];
    logic [7:0] d [2];
    wr_t        t;
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    cyc_n++;
    g[0] = if0.gnt; a[0] = if0.ack; en[0] = if0.reg_en; b[0] = if0.busy; d[0] = if0.reg_d;
    g[1] = if1.gnt; a[1] = if1.ack; en[1] = if1.reg_en; b[1] = if1.busy; d[1] = if1.reg_d;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d gnt", k),    32'(g[k]),  32'(m[k].gnt));
      chk($sformatf("dut%0d ack", k),    32'(a[k]),  32'(m[k].gnt));
      chk($sformatf("dut%0d reg_en", k), 32'(en[k]), 32'(m[k].en));
      chk($sformatf("dut%0d reg_d", k),  32'(d[k]),  32'(m[k].d));
      chk($sformatf("dut%0d busy", k),   32'(b[k]),  32'(m[k].busy));
      if (en[k]) begin
        chk($sformatf("dut%0d reg_en back-to-back", k), 32'(prev_en[k]), 32'd0);
        t.w = oh2idx(g[k]);
        t.e = cyc_n;
        if (k == 0) log0.push_back(t); else log1.push_back(t);
        $display("[TB] cycle %0d dut%0d write from req %0d data %02h", cyc_n, k, t.w, d[k]);
      end
      prev_en[k]  = en[k];
      last_ack[k] = a[k];
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dut0 gnt"},    32'(if0.gnt),    32'd0);
    chk({tag, " dut0 reg_en"}, 32'(if0.reg_en), 32'd0);
    chk({tag, " dut0 reg_d"},  32'(if0.reg_d),  32'd0);
    chk({tag, " dut0 busy"},   32'(if0.busy),   32'd0);
    chk({tag, " dut1 gnt"},    32'(if1.gnt),    32'd0);
    chk({tag, " dut1 reg_en"}, 32'(if1.reg_en), 32'd0);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      req_v[k] = '0; lock_v[k] = '0; din_v[k] = 32'h13121110;
    end
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    gap_of[0] = 1;
    gap_of[1] = 3;
    tv[0] = '{4'b0001, 32'h131211A5, 4'b0001, 8'hA5};
    tv[1] = '{4'b0001, 32'h13121110, 4'b0001, 8'h10};
    tv[2] = '{4'b1010, 32'h13121110, 4'b0010, 8'h11};
    tv[3] = '{4'b1010, 32'h13121110, 4'b1000, 8'h13};
    tv[4] = '{4'b0110, 32'h13121110, 4'b0010, 8'h11};
    tv[5] = '{4'b0110, 32'h13121110, 4'b0100, 8'h12};
    tv[6] = '{4'b0011, 32'h13121110, 4'b0001, 8'h10};
    tv[7] = '{4'b1111, 32'h13121110, 4'b0010, 8'h11};

    // Table: single-shot requests from idle; pointer carries across rows.
    do_reset();
    for (int v = 0; v < 8; v++) begin
      req_v[0] = tv[v].req;
      din_v[0] = tv[v].din;
      step();
      chk($sformatf("vec%0d gnt", v),   32'(if0.gnt),   32'(tv[v].gnt));
      chk($sformatf("vec%0d reg_d", v), 32'(if0.reg_d), 32'(tv[v].d));
      req_v[0] = '0;
      step();
      step();
      chk($sformatf("vec%0d idle busy", v),  32'(if0.busy),  32'd0);
      chk($sformatf("vec%0d reg_d held", v), 32'(if0.reg_d), 32'(tv[v].d));
    end

    // Continuous requests: dut0 all four (GAP=1), dut1 req 1 and 2 (GAP=3).
    begin
      int exp0 [5];
      int exp1 [3];
      exp0 = '{0, 1, 2, 3, 0};
      exp1 = '{1, 2, 1};
      do_reset();
      req_v[0] = 4'b1111;
      req_v[1] = 4'b0110;
      log0.delete();
      log1.delete();
      repeat (10) step();
      chk("cont dut0 writes", 32'(log0.size()), 32'd5);
      chk("cont dut1 writes", 32'(log1.size()), 32'd3);
      for (int j = 0; j < 5 && j < log0.size(); j++) begin
        chk($sformatf("cont dut0 order %0d", j), 32'(log0[j].w), 32'(exp0[j]));
        if (j > 0) chk($sformatf("cont dut0 spacing %0d", j), 32'(log0[j].e - log0[j-1].e), 32'd2);
      end
      for (int j = 0; j < 3 && j < log1.size(); j++) begin
        chk($sformatf("cont dut1 order %0d", j), 32'(log1[j].w), 32'(exp1[j]));
        if (j > 0) chk($sformatf("cont dut1 spacing %0d", j), 32'(log1[j].e - log1[j-1].e), 32'd4);
      end
    end

    // Reset asserted in the middle of a GRANT cycle.
    do_reset();
    req_v[0] = 4'b0001;
    step();
    chk("pre-reset gnt", 32'(if0.gnt), 32'b0001);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async reset");
    do_reset();
    req_v[0] = 4'b0011;
    step();
    chk("post-reset pointer", 32'(if0.gnt), 32'b0001);
    req_v[0] = '0;
    step();
    step();

    // req[3] rises during GAP with req[0] still high; pointer sits at 1.
    do_reset();
    req_v[0] = 4'b0001;
    step();
    chk("gap-rise first gnt", 32'(if0.gnt), 32'b0001);
    step();
    req_v[0] = 4'b1001;
    step();
    chk("gap-rise req3 wins", 32'(if0.gnt), 32'b1000);
    step();
    step();
    chk("gap-rise req0 next", 32'(if0.gnt), 32'b0001);
    req_v[0] = '0;
    step();
    step();

`ifdef CB_ARB_LOCK_EN
    // Lock: req 0 and 1 high, lock[0] held for three writes, then dropped.
    do_reset();
    req_v[0]  = 4'b0011;
    lock_v[0] = 4'b0001;
    log0.delete();
    repeat (5) step();
    lock_v[0] = 4'b0000;
    repeat (2) step();
    chk("lock writes", 32'(log0.size()), 32'd4);
    for (int j = 0; j < 4 && j < log0.size(); j++)
      chk($sformatf("lock order %0d", j), 32'(log0[j].w), (j < 3) ? 32'd0 : 32'd1);
    req_v[0] = '0;
    step();
    step();
`endif

    // Random traffic on both instances against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < N; i++) begin
          if (req_v[k][i]) begin
            if (last_ack[k][i] && $urandom_range(7) != 0) req_v[k][i] = 1'b0;
          end else if ($urandom_range(3) == 0) begin
            req_v[k][i]        = 1'b1;
            din_v[k][i*W +: W] = 8'($urandom);
          end
        end
`ifdef CB_ARB_LOCK_EN
        if (c % 8 == 0) lock_v[k] = 4'($urandom);
`endif
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
